vip_stream_encoder: RTL and testbench
=====================================

VIP_STREAM_ENCODER -- requirements
Module: vip_stream_encoder

Interface
REQ-001 Parameter BITS_PER_SYMBOL, default 8, bits per colour symbol.
REQ-002 Parameter SYMBOLS_PER_BEAT, default 3, parallel symbols per beat; the block supports only 3.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 din_valid  input  1  algorithm pixel write strobe.
REQ-006 din_data  input  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  pixel beat; symbol 0 is in the LSBs.
REQ-007 din_ready  output  1  pixel accepted when din_valid&din_ready.
REQ-008 end_of_video  input  1  qualifies the accepted pixel as the last of the frame.
REQ-009 width, height  input  16 each  frame dimensions, sampled on vip_ctrl_send.
REQ-010 interlaced  input  4  interlace nibble, sampled on vip_ctrl_send.
REQ-011 vip_ctrl_send  input  1  one-cycle request to emit a control packet.
REQ-012 vip_ctrl_busy  output  1  a control request is pending or in transmission.
REQ-013 dout_ready  input  1  sink ready.
REQ-014 dout_valid  output  1  beat valid.
REQ-015 dout_data  output  BITS_PER_SYMBOL*SYMBOLS_PER_BEAT  beat data.
REQ-016 dout_startofpacket, dout_endofpacket  output  1 each  packet delimiters.

Function
REQ-017 All dout_* signals are registered; the output register loads only when ~dout_valid | dout_ready, and holds otherwise.
REQ-018 FSM states: IDLE, CTRL_HDR, CTRL_PAY, VID_HDR, VIDEO.
REQ-019 vip_ctrl_send latches width/height/interlaced and sets a pending flag; vip_ctrl_busy = pending | state in {CTRL_HDR, CTRL_PAY}.
REQ-020 vip_ctrl_send while busy is ignored, and the latched values remain unchanged.
REQ-021 IDLE with pending goes to CTRL_HDR; otherwise, IDLE with din_valid goes to VID_HDR; pending has priority on the same cycle.
REQ-022 CTRL_HDR emits one beat of 0x00000F with SOP.
REQ-023 CTRL_PAY then emits 3 beats carrying 9 nibbles, one per symbol in bits [3:0] with upper bits 0, in the order width[15:12..3:0], height[15:12..3:0], interlaced.
REQ-024 The third CTRL_PAY beat carries EOP; pending clears on acceptance of the CTRL_HDR beat; the FSM then returns to IDLE.
REQ-025 VID_HDR emits 0x000000 with SOP, then enters VIDEO.
REQ-026 In VIDEO, din_ready = ~dout_valid | dout_ready; each accepted pixel is forwarded unchanged with 1-cycle latency.
REQ-027 A pixel accepted with end_of_video carries EOP and returns the FSM to IDLE.
REQ-028 din_ready = 0 in every state except VIDEO.
REQ-029 vip_ctrl_send during VIDEO is held pending and sent after the video EOP, never mid-packet.
REQ-030 A 2-bit beat counter tracks CTRL_PAY; it resets to 0 on entry and does not wrap past 2.
REQ-031 SOP and EOP are never asserted together.

Reset
REQ-032 On rst low, asynchronously: state=IDLE, dout_valid=0, SOP=EOP=0, dout_data=0, pending=0, latched width/height/interlaced=0, counter=0.
REQ-033 Reset mid-packet abandons the packet without emitting EOP; the first packet after reset starts with SOP.

Configuration
REQ-034 Macro VIP_ENCODER_AUTO_CTRL_EN.
REQ-035 When VIP_ENCODER_AUTO_CTRL_EN is defined, IDLE with din_valid and no pending request first sends a control packet from the last latched values, then the video packet.
REQ-036 When VIP_ENCODER_AUTO_CTRL_EN is not defined, control packets are sent only on vip_ctrl_send.

Verification
REQ-037 vip_ctrl_send with 640x480, interlaced=0, dout_ready=1 -> beats 0x00000F(SOP), 0x080200, 0x010000, 0x00000E(EOP); busy high until the EOP beat is accepted.
REQ-038 Pixels 0x112233, 0x445566(end_of_video), dout_ready=1 -> 0x000000(SOP), 0x112233, 0x445566(EOP); each pixel appears 1 cycle after acceptance.
REQ-039 dout_ready=0 for 5 cycles mid-video -> din_ready=0, dout_data/valid stable, no beat lost or duplicated.
REQ-040 vip_ctrl_send during VIDEO -> busy=1; the control packet starts only after the video EOP beat.
REQ-041 rst low during CTRL_PAY beat 2 -> dout_valid=0 immediately; next vip_ctrl_send -> full 4-beat packet with SOP.
REQ-042 VIP_ENCODER_AUTO_CTRL_EN defined, din_valid in IDLE with no request -> control packet (latched values) precedes video SOP; without the macro -> video SOP only.

Source files
------------

// File: rtl/vip_stream_encoder.sv
// vip_stream_encoder
// Packs an algorithm-side pixel stream into VIP-style packets: a control
// packet (header 0xF plus width/height/interlace nibbles) on request, and a
// video packet (header 0x0 plus forwarded pixels) for each frame.
// All dout_* signals come straight from an output register that only
// advances when it is empty or being accepted by the sink.
// Optional feature: define VIP_ENCODER_AUTO_CTRL_EN to make every frame
// start with a control packet built from the last latched dimensions.
// Only SYMBOLS_PER_BEAT = 3 is supported; BITS_PER_SYMBOL must be >= 4.

module vip_stream_encoder #(
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int SYMBOLS_PER_BEAT = 3
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        din_valid,
   input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
   output logic                                        din_ready,
   input  logic                                        end_of_video,
   input  logic [15:0]                                 width,
   input  logic [15:0]                                 height,
   input  logic [3:0]                                  interlaced,
   input  logic                                        vip_ctrl_send,
   output logic                                        vip_ctrl_busy,
   input  logic                                        dout_ready,
   output logic                                        dout_valid,
   output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
   output logic                                        dout_startofpacket,
   output logic                                        dout_endofpacket
);

   localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CTRL_HDR = 3'd1,
      ST_CTRL_PAY = 3'd2,
      ST_VID_HDR  = 3'd3,
      ST_VIDEO    = 3'd4
   } state_t;

   state_t          state_q;
   logic            pending_q;
   logic [15:0]     width_q;
   logic [15:0]     height_q;
   logic [3:0]      interlaced_q;
   logic [1:0]      cnt_q;
   logic            vid_after_q;
   logic            dout_valid_q;
   logic [DW-1:0]   dout_data_q;
   logic            dout_sop_q;
   logic            dout_eop_q;

   logic            out_en_s;
   logic            busy_s;
   logic            din_ready_s;
   logic            hdr_accept_s;

   // Build one control beat: a nibble in bits [3:0] of each symbol, symbol 0 lowest.
   function automatic logic [DW-1:0] ctrl_beat(input logic [3:0] s0,
                                                input logic [3:0] s1,
                                                input logic [3:0] s2);
      logic [DW-1:0] beat;
      beat                             = '0;
      beat[3:0]                        = s0;
      beat[BITS_PER_SYMBOL +: 4]       = s1;
      beat[2*BITS_PER_SYMBOL +: 4]     = s2;
      return beat;
   endfunction

   // Select the control payload beat addressed by the beat counter.
   function automatic logic [DW-1:0] pay_beat(input logic [1:0]  idx,
                                               input logic [15:0] w,
                                               input logic [15:0] h,
                                               input logic [3:0]  il);
      logic [DW-1:0] beat;
      case (idx)
         2'd0:    beat = ctrl_beat(w[15:12], w[11:8],  w[7:4]);
         2'd1:    beat = ctrl_beat(w[3:0],   h[15:12], h[11:8]);
         2'd2:    beat = ctrl_beat(h[7:4],   h[3:0],   il);
         default: beat = '0;
      endcase
      return beat;
   endfunction

   // Handshake qualifiers shared by the FSM, the request tracker and the ports.
   always_comb begin
      out_en_s     = ~dout_valid_q | dout_ready;
      busy_s       = pending_q | (state_q == ST_CTRL_HDR) | (state_q == ST_CTRL_PAY);
      din_ready_s  = (state_q == ST_VIDEO) & out_en_s;
      hdr_accept_s = (state_q == ST_CTRL_PAY) & dout_valid_q & dout_ready & dout_sop_q;
   end

   assign din_ready          = din_ready_s;
   assign vip_ctrl_busy      = busy_s;
   assign dout_valid         = dout_valid_q;
   assign dout_data          = dout_data_q;
   assign dout_startofpacket = dout_sop_q;
   assign dout_endofpacket   = dout_eop_q;

   // Latch control fields on an accepted request; drop the request once its header is taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q    <= 1'b0;
         width_q      <= 16'd0;
         height_q     <= 16'd0;
         interlaced_q <= 4'd0;
      end else if (vip_ctrl_send && !busy_s) begin
         pending_q    <= 1'b1;
         width_q      <= width;
         height_q     <= height;
         interlaced_q <= interlaced;
      end else if (hdr_accept_s) begin
         pending_q    <= 1'b0;
      end
   end

   // Packet sequencer with the registered output stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 2'd0;
         vid_after_q  <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_data_q  <= '0;
         dout_sop_q   <= 1'b0;
         dout_eop_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (out_en_s) begin
                  dout_valid_q <= 1'b0;
                  dout_sop_q   <= 1'b0;
                  dout_eop_q   <= 1'b0;
               end
               if (pending_q) begin
                  state_q <= ST_CTRL_HDR;
               end else if (din_valid) begin
`ifdef VIP_ENCODER_AUTO_CTRL_EN
                  state_q     <= ST_CTRL_HDR;
                  vid_after_q <= 1'b1;
`else
                  state_q     <= ST_VID_HDR;
`endif
               end
            end
            ST_CTRL_HDR: begin
               if (out_en_s) begin
                  dout_valid_q <= 1'b1;
                  dout_data_q  <= ctrl_beat(4'hF, 4'h0, 4'h0);
                  dout_sop_q   <= 1'b1;
                  dout_eop_q   <= 1'b0;
                  cnt_q        <= 2'd0;
                  state_q      <= ST_CTRL_PAY;
               end
            end
            ST_CTRL_PAY: begin
               if (out_en_s) begin
                  if (dout_eop_q) begin
                     // Our EOP beat is being accepted: packet complete.
                     dout_valid_q <= 1'b0;
                     dout_sop_q   <= 1'b0;
                     dout_eop_q   <= 1'b0;
                     vid_after_q  <= 1'b0;
                     state_q      <= vid_after_q ? ST_VID_HDR : ST_IDLE;
                  end else begin
                     dout_valid_q <= 1'b1;
                     dout_data_q  <= pay_beat(cnt_q, width_q, height_q, interlaced_q);
                     dout_sop_q   <= 1'b0;
                     dout_eop_q   <= (cnt_q == 2'd2);
                     if (cnt_q != 2'd2) begin
                        cnt_q <= cnt_q + 2'd1;
                     end
                  end
               end
            end
            ST_VID_HDR: begin
               if (out_en_s) begin
                  dout_valid_q <= 1'b1;
                  dout_data_q  <= '0;
                  dout_sop_q   <= 1'b1;
                  dout_eop_q   <= 1'b0;
                  state_q      <= ST_VIDEO;
               end
            end
            ST_VIDEO: begin
               if (out_en_s) begin
                  if (din_valid) begin
                     dout_valid_q <= 1'b1;
                     dout_data_q  <= din_data;
                     dout_sop_q   <= 1'b0;
                     dout_eop_q   <= end_of_video;
                     if (end_of_video) begin
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     dout_valid_q <= 1'b0;
                     dout_sop_q   <= 1'b0;
                     dout_eop_q   <= 1'b0;
                  end
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               dout_valid_q <= 1'b0;
               dout_sop_q   <= 1'b0;
               dout_eop_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vip_stream_encoder.sv
// Directed self-checking bench for vip_stream_encoder.
// Beats accepted by the sink are logged as {sop, eop, data} and compared
// against hand-computed packet tables in each scenario task.

module tb_vip_stream_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        din_valid;
   logic [23:0] din_data;
   logic        din_ready;
   logic        end_of_video;
   logic [15:0] width;
   logic [15:0] height;
   logic [3:0]  interlaced;
   logic        vip_ctrl_send;
   logic        vip_ctrl_busy;
   logic        dout_ready;
   logic        dout_valid;
   logic [23:0] dout_data;
   logic        dout_startofpacket;
   logic        dout_endofpacket;

   int errors = 0;
   int checks = 0;

   logic [25:0] mon_q[$];

   vip_stream_encoder #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3)) dut (
      .clk                (clk),
      .rst                (rst),
      .din_valid          (din_valid),
      .din_data           (din_data),
      .din_ready          (din_ready),
      .end_of_video       (end_of_video),
      .width              (width),
      .height             (height),
      .interlaced         (interlaced),
      .vip_ctrl_send      (vip_ctrl_send),
      .vip_ctrl_busy      (vip_ctrl_busy),
      .dout_ready         (dout_ready),
      .dout_valid         (dout_valid),
      .dout_data          (dout_data),
      .dout_startofpacket (dout_startofpacket),
      .dout_endofpacket   (dout_endofpacket)
   );

   always #5 clk = ~clk;

   // Log every beat the sink accepts.
   always @(posedge clk) begin
      if (rst && dout_valid && dout_ready)
         mon_q.push_back({dout_startofpacket, dout_endofpacket, dout_data});
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_beats(input int n, input string name);
      for (int k = 0; k < 300 && mon_q.size() < n; k++) tick(1);
      tick(3);
      checks++;
      if (mon_q.size() != n) begin
         errors++;
         $display("FAIL %s beat count: got %0d expected %0d", name, mon_q.size(), n);
      end
   endtask

   task automatic wait_din_ready(input string name);
      int k;
      for (k = 0; k < 100 && !din_ready; k++) tick(1);
      checks++;
      if (din_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s din_ready timeout: got %b expected 1", name, din_ready);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #2;
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset dout_valid: got %b expected 0", dout_valid); end
      checks++; if (dout_data !== 24'h0) begin errors++; $display("FAIL reset dout_data: got %h expected 000000", dout_data); end
      checks++; if (dout_startofpacket !== 1'b0 || dout_endofpacket !== 1'b0) begin errors++; $display("FAIL reset sop/eop: got %b%b expected 00", dout_startofpacket, dout_endofpacket); end
      checks++; if (vip_ctrl_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", vip_ctrl_busy); end
      checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset din_ready: got %b expected 0", din_ready); end
      tick(2);
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_ctrl_packet;
      logic [25:0] exp[4];
      logic        busy_dropped;
      exp[0] = {1'b1, 1'b0, 24'h00000F};
      exp[1] = {1'b0, 1'b0, 24'h080200};
      exp[2] = {1'b0, 1'b0, 24'h010000};
      exp[3] = {1'b0, 1'b1, 24'h00000E};
      mon_q.delete();
      width = 16'd640; height = 16'd480; interlaced = 4'd0;
      vip_ctrl_send = 1'b1;
      tick(1);
      // A second request while busy must be ignored.
      width = 16'd100; height = 16'd200; interlaced = 4'd5;
      tick(1);
      vip_ctrl_send = 1'b0;
      checks++; if (vip_ctrl_busy !== 1'b1) begin errors++; $display("FAIL ctrl busy after send: got %b expected 1", vip_ctrl_busy); end
      busy_dropped = 1'b0;
      for (int k = 0; k < 100 && mon_q.size() < 4; k++) begin
         if (!vip_ctrl_busy) busy_dropped = 1'b1;
         tick(1);
      end
      checks++; if (busy_dropped !== 1'b0) begin errors++; $display("FAIL ctrl busy early drop: got %b expected 0", busy_dropped); end
      checks++; if (vip_ctrl_busy !== 1'b0) begin errors++; $display("FAIL ctrl busy after EOP: got %b expected 0", vip_ctrl_busy); end
      tick(3);
      checks++; if (mon_q.size() != 4) begin errors++; $display("FAIL ctrl beat count: got %0d expected 4", mon_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL ctrl beat %0d: got %h expected %h", i, (i < mon_q.size()) ? mon_q[i] : 26'h0, exp[i]);
         end
      end
   endtask

   task automatic test_video;
      logic [25:0] exp[3];
      exp[0] = {1'b1, 1'b0, 24'h000000};
      exp[1] = {1'b0, 1'b0, 24'h112233};
      exp[2] = {1'b0, 1'b1, 24'h445566};
      mon_q.delete();
      din_valid = 1'b1; din_data = 24'h112233; end_of_video = 1'b0;
      wait_din_ready("video");
      tick(1);
      checks++; if (dout_valid !== 1'b1 || dout_data !== 24'h112233) begin errors++; $display("FAIL video latency p0: got %b/%h expected 1/112233", dout_valid, dout_data); end
      din_data = 24'h445566; end_of_video = 1'b1;
      tick(1);
      checks++; if (dout_data !== 24'h445566 || dout_endofpacket !== 1'b1) begin errors++; $display("FAIL video latency p1: got %h/%b expected 445566/1", dout_data, dout_endofpacket); end
      din_valid = 1'b0; end_of_video = 1'b0;
      wait_beats(3, "video");
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL video beat %0d: got %h expected %h", i, (i < mon_q.size()) ? mon_q[i] : 26'h0, exp[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [25:0] exp[3];
      exp[0] = {1'b1, 1'b0, 24'h000000};
      exp[1] = {1'b0, 1'b0, 24'hA1A2A3};
      exp[2] = {1'b0, 1'b1, 24'hB1B2B3};
      mon_q.delete();
      din_valid = 1'b1; din_data = 24'hA1A2A3; end_of_video = 1'b0;
      wait_din_ready("bp");
      tick(1);
      dout_ready = 1'b0; din_data = 24'hB1B2B3; end_of_video = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (din_ready !== 1'b0 || dout_valid !== 1'b1 || dout_data !== 24'hA1A2A3) begin
            errors++;
            $display("FAIL bp stall cycle %0d: got rdy=%b vld=%b data=%h expected 0/1/a1a2a3", c, din_ready, dout_valid, dout_data);
         end
         tick(1);
      end
      dout_ready = 1'b1;
      #1;
      tick(1);
      din_valid = 1'b0; end_of_video = 1'b0;
      wait_beats(3, "bp");
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL bp beat %0d: got %h expected %h", i, (i < mon_q.size()) ? mon_q[i] : 26'h0, exp[i]);
         end
      end
   endtask

   task automatic test_ctrl_during_video;
      logic [25:0] exp[8];
      exp[0] = {1'b1, 1'b0, 24'h000000};
      exp[1] = {1'b0, 1'b0, 24'hC0C0C0};
      exp[2] = {1'b0, 1'b0, 24'hD0D0D0};
      exp[3] = {1'b0, 1'b1, 24'hE0E0E0};
      exp[4] = {1'b1, 1'b0, 24'h00000F};
      exp[5] = {1'b0, 1'b0, 24'h030201};
      exp[6] = {1'b0, 1'b0, 24'h060504};
      exp[7] = {1'b0, 1'b1, 24'h090807};
      mon_q.delete();
      din_valid = 1'b1; din_data = 24'hC0C0C0; end_of_video = 1'b0;
      wait_din_ready("midvid");
      tick(1);
      din_data = 24'hD0D0D0;
      vip_ctrl_send = 1'b1; width = 16'h1234; height = 16'h5678; interlaced = 4'h9;
      tick(1);
      vip_ctrl_send = 1'b0;
      checks++; if (vip_ctrl_busy !== 1'b1) begin errors++; $display("FAIL midvid busy: got %b expected 1", vip_ctrl_busy); end
      din_data = 24'hE0E0E0; end_of_video = 1'b1;
      tick(1);
      din_valid = 1'b0; end_of_video = 1'b0;
      wait_beats(8, "midvid");
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL midvid beat %0d: got %h expected %h", i, (i < mon_q.size()) ? mon_q[i] : 26'h0, exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid_packet;
      logic [25:0] exp[4];
      exp[0] = {1'b1, 1'b0, 24'h00000F};
      exp[1] = {1'b0, 1'b0, 24'h080200};
      exp[2] = {1'b0, 1'b0, 24'h010000};
      exp[3] = {1'b0, 1'b1, 24'h00000E};
      mon_q.delete();
      width = 16'd640; height = 16'd480; interlaced = 4'd0;
      vip_ctrl_send = 1'b1;
      tick(1);
      vip_ctrl_send = 1'b0;
      for (int k = 0; k < 50 && mon_q.size() < 2; k++) tick(1);
      #2;
      rst = 1'b0;
      #1;
      checks++; if (dout_valid !== 1'b0 || dout_endofpacket !== 1'b0) begin errors++; $display("FAIL rstmid outputs: got vld=%b eop=%b expected 0/0", dout_valid, dout_endofpacket); end
      checks++; if (vip_ctrl_busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b expected 0", vip_ctrl_busy); end
      tick(2);
      rst = 1'b1;
      tick(1);
      mon_q.delete();
      vip_ctrl_send = 1'b1;
      tick(1);
      vip_ctrl_send = 1'b0;
      wait_beats(4, "rstmid");
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL rstmid beat %0d: got %h expected %h", i, (i < mon_q.size()) ? mon_q[i] : 26'h0, exp[i]);
         end
      end
   endtask

   task automatic test_auto_ctrl;
`ifdef VIP_ENCODER_AUTO_CTRL_EN
      localparam int N = 6;
      logic [25:0] exp[N];
      exp[0] = {1'b1, 1'b0, 24'h00000F};
      exp[1] = {1'b0, 1'b0, 24'h080200};
      exp[2] = {1'b0, 1'b0, 24'h010000};
      exp[3] = {1'b0, 1'b1, 24'h00000E};
      exp[4] = {1'b1, 1'b0, 24'h000000};
      exp[5] = {1'b0, 1'b1, 24'h0F0F0F};
`else
      localparam int N = 2;
      logic [25:0] exp[N];
      exp[0] = {1'b1, 1'b0, 24'h000000};
      exp[1] = {1'b0, 1'b1, 24'h0F0F0F};
`endif
      mon_q.delete();
      din_valid = 1'b1; din_data = 24'h0F0F0F; end_of_video = 1'b1;
      wait_din_ready("auto");
      tick(1);
      din_valid = 1'b0; end_of_video = 1'b0;
      wait_beats(N, "auto");
      for (int i = 0; i < N; i++) begin
         checks++;
         if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL auto beat %0d: got %h expected %h", i, (i < mon_q.size()) ? mon_q[i] : 26'h0, exp[i]);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      din_valid = 1'b0; din_data = 24'h0; end_of_video = 1'b0;
      width = 16'd0; height = 16'd0; interlaced = 4'd0;
      vip_ctrl_send = 1'b0; dout_ready = 1'b1;
      test_reset();
      test_ctrl_packet();
      tick(3);
      test_video();
      tick(3);
      test_backpressure();
      tick(3);
      test_ctrl_during_video();
      tick(3);
      test_reset_mid_packet();
      tick(3);
      test_auto_ctrl();
      tick(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
